sobel_window_ctrl: RTL and testbench

Frame sequencer that sits between the pixel source and the `sobel` kernel. It accepts one raster-order 8-bit pixel stream per frame and buffers two image lines plus a 3x3 column window. It emits exactly one 3x3 window per image position, in raster order, with a border flag. The downstream kernel computes the gradient only for non-border windows and forces SUM=0 on border windows.

---
 rtl/sobel_pkg.sv | 20 ++
 rtl/sobel_line_buffer.sv | 37 +++
 rtl/sobel_window_ctrl.sv | 172 +++++++++++++++++
 tb/tb_sobel_window_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types and helpers for the sobel window sequencer and its line buffers.
package sobel_pkg;

    localparam int PIX_W = 8;
    localparam int WIN_W = 9 * PIX_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } win_state_t;

    // Bit offset of pixel p[r][c] inside a packed 3x3 window.
    function automatic int win_idx(input int r, input int c);
        return PIX_W * (3 * r + c);
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// WIDTH-deep circular pixel delay line: one read and one write per shift.
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int WIDTH = 640
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift,
    input  logic [PIX_W-1:0] din,
    output logic [PIX_W-1:0] dout
);

    localparam int AW = $clog2(WIDTH);
    localparam logic [AW-1:0] LAST = AW'(WIDTH - 1);

    logic [PIX_W-1:0] mem [WIDTH];
    logic [AW-1:0]    ptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (shift) begin
            ptr <= (ptr == LAST) ? '0 : ptr + AW'(1);
        end
    end

    // Contents need no reset; only windows built from current-frame data are used.
    always_ff @(posedge clk) begin
        if (shift) begin
            mem[ptr] <= din;
        end
    end

    assign dout = mem[ptr];

endmodule

// File: rtl/sobel_window_ctrl.sv
// Raster pixel stream in, one registered 3x3 window per image position out.
//   state    | meaning
//   ST_IDLE  | waiting for start
//   ST_FILL  | priming line buffers with the first WIDTH+1 pixels
//   ST_RUN   | one window loaded per accepted pixel
//   ST_FLUSH | draining the last WIDTH+1 windows, zeros pushed in
//   ST_DONE  | one-cycle done pulse
module sobel_window_ctrl
    import sobel_pkg::*;
#(
    parameter int WIDTH = 640,
    parameter int DEPTH = 480
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    input  logic                     pix_valid,
    output logic                     pix_ready,
    input  logic [PIX_W-1:0]         pix_data,
    output logic                     win_valid,
    input  logic                     win_ready,
    output logic [WIN_W-1:0]         win_data,
    output logic                     win_border,
    output logic [$clog2(WIDTH)-1:0] win_x,
    output logic [$clog2(DEPTH)-1:0] win_y
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(DEPTH);
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(DEPTH - 1);

    win_state_t state, state_nx;

    logic [XW-1:0] in_x, ox;
    logic [YW-1:0] in_y, oy;
    logic          shift, load, slot_free, border;
    logic [PIX_W-1:0] pix_in, lb0_out, lb1_out;
    logic [2:0][PIX_W-1:0] col0, col1, ncol;
    logic [WIN_W-1:0] win_next;

    assign slot_free = !win_valid || win_ready;
    assign pix_in    = (state == ST_FLUSH) ? '0 : pix_data;
    assign ncol      = {pix_in, lb1_out, lb0_out};
    assign border    = (ox == '0) || (ox == X_LAST) || (oy == '0) || (oy == Y_LAST);

    sobel_line_buffer #(.WIDTH(WIDTH)) u_lb_row_y (
        .clk   (clk),
        .rst_n (rst_n),
        .shift (shift),
        .din   (pix_in),
        .dout  (lb1_out)
    );

    sobel_line_buffer #(.WIDTH(WIDTH)) u_lb_row_ym1 (
        .clk   (clk),
        .rst_n (rst_n),
        .shift (shift),
        .din   (lb1_out),
        .dout  (lb0_out)
    );

    always_comb begin
        win_next = '0;
        for (int r = 0; r < 3; r++) begin
            win_next[win_idx(r, 0) +: PIX_W] = col0[r];
            win_next[win_idx(r, 1) +: PIX_W] = col1[r];
            win_next[win_idx(r, 2) +: PIX_W] = ncol[r];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        pix_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        shift     = 1'b0;
        load      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_nx = ST_FILL;
            end
            ST_FILL: begin
                pix_ready = 1'b1;
                if (pix_valid) begin
                    shift = 1'b1;
                    if (in_x == '0 && in_y == YW'(1)) state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                pix_ready = slot_free;
                if (pix_valid && slot_free) begin
                    shift = 1'b1;
                    load  = 1'b1;
                    if (in_x == X_LAST && in_y == Y_LAST) state_nx = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // Output counters wrap to (0,0) once the final window is loaded.
                if (slot_free && !(ox == '0 && oy == '0)) begin
                    shift = 1'b1;
                    load  = 1'b1;
                end
                if (win_valid && win_ready && win_x == X_LAST && win_y == Y_LAST)
                    state_nx = ST_DONE;
            end
            ST_DONE: begin
                busy     = 1'b0;
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: begin
                busy     = 1'b0;
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_x       <= '0;
            in_y       <= '0;
            ox         <= '0;
            oy         <= '0;
            col0       <= '0;
            col1       <= '0;
            win_valid  <= 1'b0;
            win_data   <= '0;
            win_border <= 1'b0;
            win_x      <= '0;
            win_y      <= '0;
        end else begin
            if (state == ST_IDLE && start) begin
                in_x <= '0;
                in_y <= '0;
                ox   <= '0;
                oy   <= '0;
            end
            if (shift) begin
                col0 <= col1;
                col1 <= ncol;
                if (state != ST_FLUSH) begin
                    in_x <= (in_x == X_LAST) ? '0 : in_x + XW'(1);
                    if (in_x == X_LAST) in_y <= (in_y == Y_LAST) ? '0 : in_y + YW'(1);
                end
            end
            if (load) begin
                win_valid  <= 1'b1;
                win_data   <= border ? '0 : win_next;
                win_border <= border;
                win_x      <= ox;
                win_y      <= oy;
                ox         <= (ox == X_LAST) ? '0 : ox + XW'(1);
                if (ox == X_LAST) oy <= (oy == Y_LAST) ? '0 : oy + YW'(1);
            end else if (win_ready) begin
                win_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Directed bench: 4x4 and 3x3 frames through sobel_window_ctrl with window checking.
module tb_sobel_window_ctrl;
    import sobel_pkg::*;

    localparam int WA = 4, DA = 4, WB = 3, DB = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_a = 1'b0, start_b = 1'b0;
    logic pix_valid = 1'b0, win_ready = 1'b0;
    logic [7:0] pix_data = '0;
    logic sel = 1'b0;

    logic busy_a, done_a, pix_ready_a, win_valid_a, win_border_a;
    logic busy_b, done_b, pix_ready_b, win_valid_b, win_border_b;
    logic [71:0] win_data_a, win_data_b;
    logic [1:0] win_x_a, win_y_a, win_x_b, win_y_b;

    logic o_busy, o_done, o_pix_ready, o_win_valid, o_win_border;
    logic [71:0] o_win_data;
    logic [1:0] o_win_x, o_win_y;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sobel_window_ctrl #(.WIDTH(WA), .DEPTH(DA)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
        .pix_valid(pix_valid), .pix_ready(pix_ready_a), .pix_data(pix_data),
        .win_valid(win_valid_a), .win_ready(win_ready), .win_data(win_data_a),
        .win_border(win_border_a), .win_x(win_x_a), .win_y(win_y_a)
    );

    sobel_window_ctrl #(.WIDTH(WB), .DEPTH(DB)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
        .pix_valid(pix_valid), .pix_ready(pix_ready_b), .pix_data(pix_data),
        .win_valid(win_valid_b), .win_ready(win_ready), .win_data(win_data_b),
        .win_border(win_border_b), .win_x(win_x_b), .win_y(win_y_b)
    );

    assign o_busy       = sel ? busy_b       : busy_a;
    assign o_done       = sel ? done_b       : done_a;
    assign o_pix_ready  = sel ? pix_ready_b  : pix_ready_a;
    assign o_win_valid  = sel ? win_valid_b  : win_valid_a;
    assign o_win_border = sel ? win_border_b : win_border_a;
    assign o_win_data   = sel ? win_data_b   : win_data_a;
    assign o_win_x      = sel ? win_x_b      : win_x_a;
    assign o_win_y      = sel ? win_y_b      : win_y_a;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] exp_win(input int x, input int y, input int w, input int base);
        logic [71:0] d;
        d = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                d[8*(3*r+c) +: 8] = 8'(base + (y - 1 + r) * w + (x - 1 + c));
        return d;
    endfunction

    task automatic set_start(input logic v);
        if (sel) start_b = v;
        else     start_a = v;
    endtask

    task automatic chk_idle(input string tag);
        check({tag, "_busy"},   72'(o_busy),       72'(0));
        check({tag, "_done"},   72'(o_done),       72'(0));
        check({tag, "_wvalid"}, 72'(o_win_valid),  72'(0));
        check({tag, "_pready"}, 72'(o_pix_ready),  72'(0));
        check({tag, "_wdata"},  o_win_data,        72'(0));
        check({tag, "_border"}, 72'(o_win_border), 72'(0));
        check({tag, "_x"},      72'(o_win_x),      72'(0));
        check({tag, "_y"},      72'(o_win_y),      72'(0));
    endtask

    task automatic tail();
        repeat (2) begin
            @(negedge clk);
            check("tail_wvalid", 72'(o_win_valid), 72'(0));
            check("tail_done",   72'(o_done),      72'(0));
            check("tail_busy",   72'(o_busy),      72'(0));
            @(posedge clk); #1;
        end
    endtask

    // Called at posedge+1 with the DUT idle; returns at posedge+1.
    task automatic run_frame(input int rmode, input bit poke, input int abort, input int base);
        int w, d, pidx, nwin, ndone, nint, last_hs, x, y;
        bit fin, first_seen, bord;
        w = sel ? WB : WA;
        d = sel ? DB : DA;
        pidx = 0; nwin = 0; ndone = 0; nint = 0; last_hs = -10;
        fin = 0; first_seen = 0;
        set_start(1'b1);
        pix_valid = 1'b1;
        pix_data  = 8'(base);
        win_ready = 1'b1;
        @(posedge clk); #1;
        set_start(1'b0);
        for (int c = 0; c < 400 && !fin; c++) begin
            win_ready = (rmode == 0) ? 1'b1 : (c % 3 == 2);
            pix_valid = (pidx < w * d);
            pix_data  = 8'(base + pidx);
            if (poke) set_start(nwin == 7 || nwin == 13);
            if (abort > 0 && pidx == abort) begin
                rst_n = 1'b0;
                pix_valid = 1'b0;
                @(posedge clk); #1;
                chk_idle("abort");
                rst_n = 1'b1;
                set_start(1'b0);
                return;
            end
            @(negedge clk);
            if (c == 0) begin
                check("start_pready", 72'(o_pix_ready), 72'(1));
                check("start_busy",   72'(o_busy),      72'(1));
            end
            if (o_win_valid && !first_seen) begin
                first_seen = 1;
                check("fill_pixels", 72'(pidx), 72'(w + 2));
            end
            if (o_busy && o_win_valid && !win_ready)
                check("stall_pready", 72'(o_pix_ready), 72'(0));
            if (o_pix_ready && pix_valid) pidx++;
            if (o_win_valid && win_ready) begin
                x = nwin % w;
                y = nwin / w;
                bord = (x == 0) || (y == 0) || (x == w - 1) || (y == d - 1);
                check("win_x",      72'(o_win_x),      72'(x));
                check("win_y",      72'(o_win_y),      72'(y));
                check("win_border", 72'(o_win_border), 72'(bord));
                check("win_data",   o_win_data, bord ? 72'(0) : exp_win(x, y, w, base));
                if (!bord) nint++;
                if (base == 0 && w == 4 && x == 1 && y == 1)
                    check("win_1_1", o_win_data, 72'h0a0908060504020100);
                if (base == 0 && w == 4 && x == 2 && y == 2)
                    check("win_2_2", o_win_data, 72'h0f0e0d0b0a09070605);
                if (base == 0 && w == 3 && x == 1 && y == 1)
                    check("win3_1_1", o_win_data, 72'h080706050403020100);
                nwin++;
                last_hs = c;
            end
            if (o_done) begin
                ndone++;
                check("done_latency", 72'(c), 72'(last_hs + 1));
                if (rmode == 0) check("frame_cycles", 72'(c), 72'(w * d + w + 2));
                fin = 1;
            end
            @(posedge clk); #1;
        end
        set_start(1'b0);
        pix_valid = 1'b0;
        check("n_windows",  72'(nwin),  72'(w * d));
        check("n_done",     72'(ndone), 72'(1));
        check("n_pixels",   72'(pidx),  72'(w * d));
        check("n_interior", 72'(nint),  72'((w - 2) * (d - 2)));
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        sel = 1'b0; chk_idle("rst_a");
        sel = 1'b1; chk_idle("rst_b");
        sel = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 4x4 frame, kernel always ready
        run_frame(0, 0, 0, 0);
        tail();
        // same frame, kernel ready one cycle in three
        run_frame(1, 0, 0, 0);
        tail();
        // reset after 7 pixels, then a clean frame
        run_frame(0, 0, 7, 0);
        run_frame(0, 0, 0, 0);
        tail();
        // start pulses during RUN and FLUSH are ignored
        run_frame(0, 1, 0, 0);
        tail();
        // back-to-back frames, second start two cycles after final handshake
        run_frame(0, 0, 0, 0);
        run_frame(0, 0, 0, 16);
        tail();
        // 3x3 instance
        sel = 1'b1;
        run_frame(0, 0, 0, 0);
        tail();
        run_frame(1, 0, 0, 32);
        tail();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
